// File: rtl/cond_exec_ctrl_if.sv
// Control/datapath bundle between the main control FSM (master) and the
// conditional-execution controller (slave).
interface cond_exec_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             decode_valid;
  logic             instr_done;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             NextPC;
  logic             RegW;
  logic             MemW;

  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic             CondEx;
  logic             busy;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  modport master (
    output decode_valid, instr_done, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx, busy, exec_cnt, skip_cnt
  );

  modport slave (
    input  decode_valid, instr_done, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx, busy, exec_cnt, skip_cnt
  );
endinterface

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution controller: owns the NZCV register, latches the
// condition result at decode and gates the instruction's architectural writes.
module cond_exec_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  cond_exec_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [3:0]       flags_q;
  logic             cond_ex_q;
  logic [CNT_W-1:0] exec_cnt_q;
  logic [CNT_W-1:0] skip_cnt_q;

  logic             flag_n, flag_z, flag_c, flag_v, ge;
  logic             cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign ge = (flag_n == flag_v);

  // Evaluated against the architectural flags, never the ALU's in-flight flags.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // cond_pass unassigned, which would otherwise infer a latch.
    cond_pass = 1'b0;
    case (bus.Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~(flag_c & ~flag_z);
      4'b1010: cond_pass = ge;
      4'b1011: cond_pass = ~ge;
      4'b1100: cond_pass = ~flag_z & ge;
      4'b1101: cond_pass = ~(~flag_z & ge);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values of each other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      flags_q    <= 4'b0000;
      cond_ex_q  <= 1'b0;
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.decode_valid) begin
            cond_ex_q <= cond_pass;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (cond_ex_q) begin
            if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
          end
          // A decode_valid seen here belongs to no instruction and is dropped.
          if (bus.instr_done) begin
            state <= IDLE;
            if (cond_ex_q) begin
              if (exec_cnt_q != CNT_MAX) exec_cnt_q <= exec_cnt_q + CNT_W'(1);
            end else begin
              if (skip_cnt_q != CNT_MAX) skip_cnt_q <= skip_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch (NextPC) bypasses the gate; everything else needs a passing condition.
  assign bus.RegWrite = (state == EXEC) & bus.RegW & cond_ex_q;
  assign bus.MemWrite = (state == EXEC) & bus.MemW & cond_ex_q;
  assign bus.PCWrite  = ((state == EXEC) & bus.PCS & cond_ex_q) | bus.NextPC;

  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex_q;
  assign bus.busy     = (state == EXEC);
  assign bus.exec_cnt = exec_cnt_q;
  assign bus.skip_cnt = skip_cnt_q;

endmodule
